// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
// Holds the default parameter values, the sequencer state encoding, the
// reserved halt encoding and the opcode constants used by decode.
package fetch_sequencer_pkg;

  localparam int          ADDR_W_DEF    = 4;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Primary opcodes (instruction bits [31:26]) seen by decode
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// pc_next_logic: combinational next-PC selection for the RUN state.
// Ports:
//   pc            current word address
//   stall         hold pc (any redirect this cycle is dropped)
//   jump          unconditional jump, target = jump_target[ADDR_W-1:0]
//   jump_target   26-bit jump field from decode
//   branch_taken  conditional branch, target = pc + 1 + offset
//   branch_offset 16-bit signed word offset from decode
//   pc_next       selected next pc (jump > branch > sequential)
module pc_next_logic #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  output logic [ADDR_W-1:0] pc_next
);

  // Only the low ADDR_W bits of the offset matter: the sum wraps modulo
  // the memory depth, so sign extension beyond ADDR_W cannot change it.
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;

  assign pc_inc = pc + ADDR_W'(1);
  assign pc_br  = pc_inc + branch_offset[ADDR_W-1:0];

  always_comb begin
    pc_next = pc_inc;
    if (stall)             pc_next = pc;
    else if (jump)         pc_next = jump_target[ADDR_W-1:0];
    else if (branch_taken) pc_next = pc_br;
  end

  // Upper field bits fall outside the addressable range
  logic unused_bits;
  assign unused_bits = ^{jump_target[25:ADDR_W], branch_offset[15:ADDR_W]};

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the instruction memory address and write ports.
// BOOT: accepts program words on a valid/ready stream and writes them
//       to consecutive addresses starting at 0.
// RUN : drives instruction_addr = pc, advances pc sequentially or on
//       branch/jump redirect, holds on stall, detects the halt word.
// HALT: sticky until reset.
// Ports:
//   clk, rst (async, active low)
//   load_valid/load_data/load_last/load_ready  program load stream
//   imem_we/imem_waddr/imem_wdata               memory write port
//   instruction_addr/instruction                memory read port (comb read)
//   stall/branch_taken/branch_offset/jump/jump_target  redirect controls
//   fetch_valid, halt, loaded_words             status
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] instruction_addr,
  input  logic [DATA_W-1:0] instruction,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic              fetch_valid,
  output logic              halt,
  output logic [ADDR_W:0]   loaded_words
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0] pc_next;
  logic              load_fire;
  logic              load_done;
  logic              halt_hit;

  pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc            (pc_q),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_next       (pc_next)
  );

  assign load_fire = (state_q == ST_BOOT) && load_valid;
  // Boot ends on the explicit last word or when the top address is written
  assign load_done = load_fire && (load_last || (wptr_q == {ADDR_W{1'b1}}));
  // A stalled halt word is not yet consumed, so it cannot halt
  assign halt_hit  = (state_q == ST_RUN) && !stall && (instruction == HALT_WORD);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: if (load_done) state_d = ST_RUN;
      ST_RUN:  if (halt_hit)  state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d   = pc_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_BOOT: begin
        // pc stays at 0 so RUN starts fetching from the first loaded word
        pc_d = '0;
        if (load_fire) begin
          wptr_d = wptr_q + ADDR_W'(1);
          cnt_d  = cnt_q + (ADDR_W+1)'(1);
        end
      end
      // Halt check wins over any redirect; pc keeps the halt word address
      ST_RUN:  if (!halt_hit) pc_d = pc_next;
      default: pc_d = pc_q;
    endcase
  end

  // Outputs
  always_comb begin
    load_ready  = 1'b0;
    imem_we     = 1'b0;
    fetch_valid = 1'b0;
    halt        = 1'b0;
    case (state_q)
      ST_BOOT: begin
        load_ready = 1'b1;
        imem_we    = load_valid;
      end
      ST_RUN:  fetch_valid = 1'b1;
      ST_HALT: halt        = 1'b1;
      default: ;
    endcase
  end

  assign imem_waddr       = wptr_q;
  assign imem_wdata       = load_data;
  assign instruction_addr = pc_q;
  assign loaded_words     = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int          AW   = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] HW   = 32'hFFFF_FFFF;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        imem_we;
  logic [3:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [3:0]  instruction_addr;
  logic [31:0] instruction = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        fetch_valid;
  logic        halt;
  logic [4:0]  loaded_words;

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instruction_addr(instruction_addr), .instruction(instruction),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .fetch_valid(fetch_valid), .halt(halt), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode, m_pc, m_wptr, m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 0; m_wptr = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("load_ready", 64'(load_ready), 64'(m_mode == M_BOOT));
    chk("fetch_valid", 64'(fetch_valid), 64'(m_mode == M_RUN));
    chk("halt", 64'(halt), 64'(m_mode == M_HALT));
    chk("instruction_addr", 64'(instruction_addr), 64'(m_pc));
    chk("loaded_words", 64'(loaded_words), 64'(m_cnt));
    chk("imem_we", 64'(imem_we), 64'(m_mode == M_BOOT && load_valid));
    if (m_mode == M_BOOT && load_valid) begin
      chk("imem_waddr", 64'(imem_waddr), 64'(m_wptr));
      chk("imem_wdata", 64'(imem_wdata), 64'(load_data));
    end
  endtask

  // Apply one cycle of inputs: check outputs, advance the model, clock.
  task automatic step(input logic lv, input logic [31:0] ld, input logic ll,
                      input logic st, input logic br, input logic [15:0] off,
                      input logic j, input logic [25:0] jt, input logic [31:0] ins);
    int off_s;
    load_valid = lv; load_data = ld; load_last = ll;
    stall = st; branch_taken = br; branch_offset = off;
    jump = j; jump_target = jt; instruction = ins;
    #1;
    check_outputs();
    case (m_mode)
      M_BOOT: if (lv) begin
        m_cnt++;
        if (ll || m_wptr == DEPTH-1) begin
          m_mode = M_RUN; m_pc = 0;
        end
        m_wptr = (m_wptr + 1) % DEPTH;
      end
      M_RUN: if (!st) begin
        if (ins == HW) m_mode = M_HALT;
        else if (j) m_pc = int'(jt) % DEPTH;
        else if (br) begin
          off_s = int'($signed(off));
          m_pc = (((m_pc + 1 + off_s) % DEPTH) + DEPTH) % DEPTH;
        end else m_pc = (m_pc + 1) % DEPTH;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ins);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, ins);
  endtask

  task automatic jmp(input int t);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'(t), 32'h0);
  endtask

  task automatic do_reset();
    load_valid = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    instruction = '0;
    rst = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    // Reset state
    #3;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Boot 3 words, last on the third
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1000 + 32'(i), i == 2, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    chk("boot3_count", 64'(loaded_words), 64'd3);
    chk("boot3_run", 64'(fetch_valid), 64'd1);
    chk("boot3_addr", 64'(instruction_addr), 64'd0);
    // load_valid in RUN is ignored
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);

    // Sequential wrap from 14
    jmp(14);
    for (int i = 0; i < 4; i++) idle(32'h0);
    chk("wrap_addr", 64'(instruction_addr), 64'd2);
    // Branch at pc=2, offset 1 -> 4
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 26'h0, 32'h0);
    chk("branch_pc", 64'(instruction_addr), 64'd4);
    // Negative offset: pc=4, offset -3 -> 2
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 26'h0, 32'h0);
    chk("branch_neg", 64'(instruction_addr), 64'd2);
    // Jump at pc=7 to 3
    jmp(7);
    jmp(3);
    chk("jump_pc", 64'(instruction_addr), 64'd3);
    // Jump beats branch at pc=5
    jmp(5);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 26'd9, 32'h0);
    chk("jump_over_branch", 64'(instruction_addr), 64'd9);
    // Stall drops redirect at pc=6
    jmp(6);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 26'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 26'd1, 32'h0);
    chk("stall_hold", 64'(instruction_addr), 64'd6);
    idle(32'h0);
    chk("stall_release", 64'(instruction_addr), 64'd7);
    // Stalled halt word does not halt; then halt beats jump at pc=4
    jmp(4);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, HW);
    chk("stalled_halt", 64'(halt), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 26'd8, HW);
    chk("halt_set", 64'(halt), 64'd1);
    chk("halt_pc", 64'(instruction_addr), 64'd4);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'd2, 32'h0);
    do_reset();

    // Boot 16 words without load_last -> automatic RUN
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    chk("boot16_count", 64'(loaded_words), 64'd16);
    chk("boot16_ready", 64'(load_ready), 64'd0);
    step(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    chk("boot16_count_hold", 64'(loaded_words), 64'd16);

    // Randomised run against the model, with occasional resets
    begin
      int halt_cycles = 0;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 199) == 0 || halt_cycles > 4) begin
          do_reset();
          halt_cycles = 0;
        end else begin
          step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
               $urandom_range(0, 5) == 0, 26'($urandom),
               ($urandom_range(0, 29) == 0) ? HW : 32'($urandom_range(0, 32'h7FFF_FFFF)));
          if (m_mode == M_HALT) halt_cycles++;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the instruction memory's address port and its write path.
- After reset it boot-loads the program through a valid/ready stream, then runs the fetch sequence: sequential PC, branch/jump redirect, stall hold, halt detect.
- Sits between the program loader / testbench, the instruction memory and the decode/branch logic of the single-cycle datapath.

Parameters:
ADDR_W, 4, word-address width; memory depth is 2**ADDR_W (16 words)
DATA_W, 32, instruction width
HALT_WORD, 32'hFFFF_FFFF, reserved encoding that stops fetch

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
load_valid  in  1  loader presents a word
load_data  in  DATA_W  instruction word to store
load_last  in  1  marks the final word of the program
load_ready  out  1  sequencer accepts load words (BOOT state only)
imem_we  out  1  write strobe to instruction memory
imem_waddr  out  ADDR_W  write address
imem_wdata  out  DATA_W  write data (= load_data)
instruction_addr  out  ADDR_W  fetch address (= pc)
instruction  in  DATA_W  word returned by instruction memory, combinational read
stall  in  1  hold pc this cycle
branch_taken  in  1  take conditional branch
branch_offset  in  16  signed word offset from decode
jump  in  1  take unconditional jump
jump_target  in  26  jump field from decode
fetch_valid  out  1  instruction is a live fetch (RUN state)
halt  out  1  sequencer halted
loaded_words  out  ADDR_W+1  count of words written in BOOT

Behaviour:
- Reset (rst low, async), all registered:
  - state=BOOT, pc=0, wptr=0, loaded_words=0.
  - Outputs: load_ready=1, fetch_valid=0, halt=0, instruction_addr=0.
  - Reset mid-load or mid-run aborts immediately. Memory contents are not cleared.
- State outputs:
  - BOOT: load_ready=1, imem_we = load_valid (combinational), imem_waddr=wptr, imem_wdata=load_data. fetch_valid=0.
  - RUN: fetch_valid=1, load_ready=0, imem_we=0.
  - HALT: all of fetch_valid, load_ready, imem_we are 0; halt=1.
- BOOT: each cycle with load_valid=1 writes one word, then wptr++ and loaded_words++.
- BOOT -> RUN on the handshake where load_last=1, or the handshake that writes address 2**ADDR_W-1 (full).
  - Entering RUN sets pc=0 and makes fetch_valid=1 the next cycle.
  - load_valid while not in BOOT is ignored; no write, no count.
- RUN pc update, evaluated only when stall=0. Priority is jump > branch > sequential:
  - jump: pc <= jump_target[ADDR_W-1:0].
  - branch_taken: pc <= pc + 1 + branch_offset[ADDR_W-1:0], modulo 2**ADDR_W (MIPS PC+4+offset<<2 in word units).
  - else: pc <= pc + 1, wrapping 15 -> 0.
  - stall=1 holds pc; redirects in the same cycle are dropped, so decode must hold them until stall falls.
- Halt: in RUN with stall=0 and instruction==HALT_WORD, go to HALT the next cycle.
  - pc holds the halt word's address.
  - Halt check has priority over jump and branch in the same cycle.
- HALT is sticky; only reset leaves it.
- Latency: instruction_addr is pc, the instruction arrives combinationally the same cycle, redirect takes effect the next cycle.

Decomposition:
- Shared package: state encoding (BOOT, RUN, HALT), HALT_WORD, ADDR_W/DATA_W defaults, opcode constants (LW 6'b100011, SW 6'b101011, BEQ 6'b000100, J 6'b000010).
- One combinational sub-module, pc_next_logic: inputs pc, stall, jump, jump_target, branch_taken, branch_offset; output next pc. Unit-testable on its own.

Test Plan:
- Boot of 3 words with load_last on the 3rd, load_valid held high -> imem_we for 3 cycles at waddr 0,1,2; loaded_words=3; RUN next cycle; instruction_addr=0, fetch_valid=1.
- Boot of 16 words with no load_last -> 16 writes at addr 0..15, automatic RUN, load_ready=0 afterwards; extra load_valid produces no write.
- RUN sequential from pc=14 with no redirects -> addresses 14,15,0,1 (wrap).
- At pc=2: branch_taken=1, offset=1 -> next pc=4. At pc=7: jump=1, target=3 -> next pc=3. jump and branch together at pc=5, target=9, offset=2 -> pc=9.
- stall=1 for 2 cycles at pc=6 with branch_taken=1 -> pc stays 6; after stall drops with branch_taken=0 -> pc=7.
- instruction=32'hFFFF_FFFF at pc=4 -> halt=1 next cycle, fetch_valid=0, pc=4 held. Reset pulse -> BOOT, pc=0, load_ready=1, halt=0.
